// File: rtl/vrc_cfg_loader.sv
// Serial configuration loader with CRC-8 check, triple-redundant active register and
// periodic majority scrubber for the reconfigurable next-state logic select bus.
module vrc_cfg_loader #(
  parameter int CFG_W        = 86,
  parameter int SCRUB_PERIOD = 1024,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_ready,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic                 busy,
  output logic [CFG_W:1]       Sel,
  output logic                 sel_valid,
  output logic [ERR_CNT_W-1:0] scrub_err_cnt
);

  localparam int CNT_W = $clog2(CFG_W);
  localparam int TMR_W = $clog2(SCRUB_PERIOD);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_CFG,
    SHIFT_CRC,
    CHECK,
    SCRUB
  } state_t;

  state_t state, next_state;

  logic [CFG_W:1] shadow;
  logic [CFG_W:1] copy0, copy1, copy2;
  logic [CFG_W:1] vote;
  logic [7:0]     crc, crc_next, rx_crc;
  logic [CNT_W-1:0] bit_cnt;
  logic [TMR_W-1:0] scrub_tmr;
  logic           xfer;
  logic           crc_fb;
  logic           upset;
  logic           timer_expired;

  assign cfg_ready     = (state == SHIFT_CFG) || (state == SHIFT_CRC);
  assign busy          = (state != IDLE);
  assign xfer          = cfg_valid && cfg_ready;
  assign timer_expired = (scrub_tmr == TMR_W'(SCRUB_PERIOD - 1));

  // Sel is a pure combinational vote, so a scrub rewriting a minority copy never moves it.
  assign vote  = (copy0 & copy1) | (copy0 & copy2) | (copy1 & copy2);
  assign Sel   = vote;
  assign upset = (copy0 != vote) || (copy1 != vote) || (copy2 != vote);

  assign crc_fb   = crc[7] ^ cfg_bit;
  assign crc_next = {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cfg_start)          next_state = SHIFT_CFG;
        else if (timer_expired) next_state = SCRUB;
      end
      SHIFT_CFG: if (xfer && bit_cnt == CNT_W'(CFG_W - 1)) next_state = SHIFT_CRC;
      SHIFT_CRC: if (xfer && bit_cnt == CNT_W'(7))         next_state = CHECK;
      CHECK:     next_state = IDLE;
      SCRUB:     next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Datapath: the bit counter is reused for the config field and the CRC trailer.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow        <= '0;
      copy0         <= '0;
      copy1         <= '0;
      copy2         <= '0;
      crc           <= 8'h00;
      rx_crc        <= 8'h00;
      bit_cnt       <= '0;
      scrub_tmr     <= '0;
      sel_valid     <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
      scrub_err_cnt <= '0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            shadow  <= '0;
            crc     <= 8'h00;
            rx_crc  <= 8'h00;
            bit_cnt <= '0;
          end else if (timer_expired) begin
            scrub_tmr <= '0;
          end else begin
            scrub_tmr <= scrub_tmr + 1'b1;
          end
        end
        SHIFT_CFG: begin
          if (xfer) begin
            shadow  <= {shadow[CFG_W-1:1], cfg_bit};
            crc     <= crc_next;
            bit_cnt <= (bit_cnt == CNT_W'(CFG_W - 1)) ? '0 : bit_cnt + 1'b1;
          end
        end
        SHIFT_CRC: begin
          if (xfer) begin
            rx_crc  <= {rx_crc[6:0], cfg_bit};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        CHECK: begin
          scrub_tmr <= '0;
          if (rx_crc == crc) begin
            copy0     <= shadow;
            copy1     <= shadow;
            copy2     <= shadow;
            sel_valid <= 1'b1;
            cfg_done  <= 1'b1;
          end else begin
            cfg_err <= 1'b1;
          end
        end
        SCRUB: begin
          copy0 <= vote;
          copy1 <= vote;
          copy2 <= vote;
          if (upset && scrub_err_cnt != '1) scrub_err_cnt <= scrub_err_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vrc_cfg_loader.sv
// Self-checking bench for vrc_cfg_loader: table-driven loads, scrub/upset sequences and
// randomized stalled loads against a behavioural model (long-division CRC, per-bit vote).
module tb_vrc_cfg_loader;

  localparam int CFG_W = 86;
  localparam int SP    = 16;
  localparam int EW    = 2;
  localparam int CNT_MAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst, cfg_start, cfg_valid, cfg_bit;
  logic cfg_ready, cfg_done, cfg_err, busy, sel_valid;
  logic [CFG_W-1:0] sel;
  logic [EW-1:0]    cnt;

  int total = 0;
  int bad   = 0;

  logic [CFG_W-1:0] mc [3];
  logic             mvalid;
  int               mcnt;

  typedef struct {
    logic [CFG_W-1:0] cfg;
    logic [7:0]       crc;
    bit               stall;
    bit               exp_done;
    logic [CFG_W-1:0] exp_sel;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  vrc_cfg_loader #(.CFG_W(CFG_W), .SCRUB_PERIOD(SP), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err), .busy(busy),
    .Sel(sel), .sel_valid(sel_valid), .scrub_err_cnt(cnt)
  );

  // CRC as remainder of msg * x^8 divided by x^8 + x^2 + x + 1.
  function automatic logic [7:0] crc8(input logic [CFG_W-1:0] d);
    logic [CFG_W+7:0] r;
    r = {d, 8'h00};
    for (int i = CFG_W + 7; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  function automatic logic [CFG_W-1:0] majority(input logic [CFG_W-1:0] a, b, c);
    logic [CFG_W-1:0] r;
    for (int i = 0; i < CFG_W; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  function automatic logic [CFG_W-1:0] randCfg();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[CFG_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) checkBit("idle_timeout", busy, 1'b0);
  endtask

  // Full load: start, serial transfer of config + trailer, then CHECK / result timing.
  task automatic applyStimulus(input logic [CFG_W-1:0] cfg, input logic [7:0] crcv,
                               input bit stall, input bit exp_done,
                               input logic [CFG_W-1:0] exp_sel);
    logic [CFG_W+7:0] stream;
    stream = {cfg, crcv};
    waitIdle();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    checkBit("ready_after_start", cfg_ready, 1'b1);
    for (int i = CFG_W + 7; i >= 0; i--) begin
      int  tries;
      bit  sent;
      tries = 0;
      sent  = 1'b0;
      while (!sent) begin
        cfg_valid = (stall && tries < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
        cfg_bit   = cfg_valid ? stream[i] : 1'($urandom_range(0, 1));
        cfg_start = stall ? 1'($urandom_range(0, 7) == 0) : 1'b0;
        sent      = cfg_valid;
        tries++;
        tick();
      end
    end
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    cfg_bit   = 1'b0;
    checkBit("check_busy", busy, 1'b1);
    checkBit("check_ready", cfg_ready, 1'b0);
    checkBit("check_done_early", cfg_done, 1'b0);
    checkBit("check_err_early", cfg_err, 1'b0);
    tick();
    checkBit("done_pulse", cfg_done, exp_done);
    checkBit("err_pulse", cfg_err, !exp_done);
    checkOutput("sel_after_load", 128'(sel), 128'(exp_sel));
    checkBit("sel_valid_after_load", sel_valid, exp_done ? 1'b1 : mvalid);
    checkBit("busy_after_load", busy, 1'b0);
    tick();
    checkBit("done_one_cycle", cfg_done, 1'b0);
    checkBit("err_one_cycle", cfg_err, 1'b0);
    if (exp_done) begin
      for (int k = 0; k < 3; k++) mc[k] = cfg;
      mvalid = 1'b1;
    end
  endtask

  task automatic injectUpset(input int k, input logic [CFG_W-1:0] mask);
    mc[k] = mc[k] ^ mask;
    case (k)
      0: begin force dut.copy0 = mc[0]; release dut.copy0; end
      1: begin force dut.copy1 = mc[1]; release dut.copy1; end
      default: begin force dut.copy2 = mc[2]; release dut.copy2; end
    endcase
    #1;
    checkOutput("sel_after_upset", 128'(sel), 128'(majority(mc[0], mc[1], mc[2])));
  endtask

  task automatic waitScrub();
    int n;
    logic [CFG_W-1:0] v;
    n = 0;
    while (busy !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkBit("scrub_seen", busy, 1'b1);
    tick();
    v = majority(mc[0], mc[1], mc[2]);
    if (mc[0] != v || mc[1] != v || mc[2] != v) mcnt = (mcnt < CNT_MAX) ? mcnt + 1 : CNT_MAX;
    for (int k = 0; k < 3; k++) mc[k] = v;
    checkOutput("scrub_cnt", 128'(cnt), 128'(mcnt));
    checkOutput("scrub_sel", 128'(sel), 128'(v));
    checkOutput("scrub_copy0", 128'(dut.copy0), 128'(v));
    checkOutput("scrub_copy1", 128'(dut.copy1), 128'(v));
    checkOutput("scrub_copy2", 128'(dut.copy2), 128'(v));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_sel"}, 128'(sel), 128'(0));
    checkBit({tag, "_sel_valid"}, sel_valid, 1'b0);
    checkBit({tag, "_busy"}, busy, 1'b0);
    checkBit({tag, "_ready"}, cfg_ready, 1'b0);
    checkBit({tag, "_done"}, cfg_done, 1'b0);
    checkBit({tag, "_err"}, cfg_err, 1'b0);
    checkOutput({tag, "_cnt"}, 128'(cnt), 128'(0));
  endtask

  initial begin
    logic [CFG_W-1:0] rc;
    logic [CFG_W-1:0] one;
    one = '0;
    one[0] = 1'b1;

    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    for (int k = 0; k < 3; k++) mc[k] = '0;
    mvalid = 1'b0;
    mcnt   = 0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Idle with valid data that must be ignored while not ready.
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'($urandom_range(0, 1));
      tick();
    end
    cfg_valid = 1'b0;
    checkResetState("reset");

    rc = randCfg();
    tbl[0] = '{cfg: '0,  crc: 8'h00, stall: 1'b0, exp_done: 1'b1, exp_sel: '0};
    tbl[1] = '{cfg: one, crc: 8'h07, stall: 1'b0, exp_done: 1'b1, exp_sel: one};
    tbl[2] = '{cfg: '0,  crc: 8'h01, stall: 1'b0, exp_done: 1'b0, exp_sel: one};
    tbl[3] = '{cfg: rc,  crc: crc8(rc), stall: 1'b1, exp_done: 1'b1, exp_sel: rc};
    tbl[4] = '{cfg: ~rc, crc: crc8(~rc) ^ 8'h80, stall: 1'b1, exp_done: 1'b0, exp_sel: rc};
    tbl[5] = '{cfg: '1,  crc: crc8('1), stall: 1'b0, exp_done: 1'b1, exp_sel: '1};
    tbl[6] = '{cfg: one, crc: 8'h07, stall: 1'b1, exp_done: 1'b1, exp_sel: one};

    for (int t = 0; t < 7; t++)
      applyStimulus(tbl[t].cfg, tbl[t].crc, tbl[t].stall, tbl[t].exp_done, tbl[t].exp_sel);

    // Single upset on the top bit of copy1, repaired once; clean pass leaves count alone.
    waitIdle();
    injectUpset(1, one << (CFG_W - 1));
    waitScrub();
    waitScrub();

    // Saturating count: single, multi-bit and double-copy upsets ahead of five scrubs.
    for (int i = 0; i < 5; i++) begin
      int b1, b2;
      b1 = $urandom_range(0, CFG_W - 1);
      b2 = (b1 + 1 + $urandom_range(0, CFG_W - 2)) % CFG_W;
      waitIdle();
      case (i)
        2: begin
          injectUpset(0, one << b1);
          injectUpset(2, one << b2);
        end
        3: begin
          injectUpset(0, one << b1);
          injectUpset(1, one << b1);
        end
        default: injectUpset(i % 3, one << b1);
      endcase
      waitScrub();
    end

    // Randomized loads with stalls, garbage bits and ignored mid-load starts.
    for (int t = 0; t < 8; t++) begin
      logic [CFG_W-1:0] c;
      logic [7:0]       r;
      bit               ok;
      c  = randCfg();
      ok = ($urandom_range(0, 2) != 0);
      r  = ok ? crc8(c) : crc8(c) ^ 8'(1 << $urandom_range(0, 7));
      applyStimulus(c, r, 1'b1, ok, ok ? c : majority(mc[0], mc[1], mc[2]));
    end

    // Reset in the middle of SHIFT_CFG discards everything.
    waitIdle();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_bit   = 1'($urandom_range(0, 1));
      tick();
    end
    checkBit("midload_busy", busy, 1'b1);
    rst = 1'b1;
    cfg_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) mc[k] = '0;
    mvalid = 1'b0;
    mcnt   = 0;
    checkResetState("midload_reset");

    rc = randCfg();
    applyStimulus(rc, crc8(rc), 1'b1, 1'b1, rc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
